aes_round_key_sched: RTL

- AES-128 key-expansion and round-key server.
- Sits beside aes_pnm_controller and feeds the PE array's AddRoundKey step with a 128-bit round key selected by the controller's round index.
- Expands the cipher key once into a 44-word (11 round-key) store, one word per cycle.
- Serves any round key in any order with 1-cycle read latency, so encryption (0..10) and decryption (10..0) use the same store.

---
 rtl/aes_round_key_sched.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/aes_round_key_sched.sv
// AES-128 key expansion and round-key server.
// Expands the cipher key into a 44-word store, one word per cycle. Any of the
// 11 round keys can then be read in any order with a 1-cycle registered latency.
module aes_round_key_sched #(
    parameter int N_ROUNDS        = 10,
    parameter bit ZERO_ON_INVALID = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic         key_ready,
    input  logic         rk_rd_en,
    input  logic [3:0]   rk_rd_round,
    output logic [127:0] rk_out,
    output logic         rk_valid,
    output logic         rk_err
);

    localparam int         N_WORDS   = 4 * (N_ROUNDS + 1);
    localparam logic [5:0] LAST_IDX  = 6'(N_WORDS - 1);
    localparam logic [3:0] MAX_ROUND = 4'(N_ROUNDS);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY} state_t;

    state_t       state_q, state_d;
    logic [5:0]   idx_q, idx_d;
    logic [31:0]  w_q [N_WORDS];
    logic [127:0] rk_out_q;
    logic         rk_valid_q, rk_err_q;

    logic [5:0]   prev_idx, back_idx, rd_base;
    logic [31:0]  temp, new_word;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // S-box: multiplicative inverse (x^254, so 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, base, e, b;
        r    = 8'h01;
        base = x;
        e    = 8'd254;
        for (int k = 0; k < 8; k++) begin
            if (e[k]) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        b = r;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Next-state logic: key_load restarts expansion from any state.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        state_d = state_q;
        idx_d   = idx_q;
        if (key_load) begin
            state_d = S_EXPAND;
            idx_d   = 6'd4;
        end else if (state_q == S_EXPAND) begin
            idx_d = idx_q + 6'd1;
            if (idx_q == LAST_IDX) state_d = S_READY;
        end
    end

    // Compute W[i] from W[i-1] and W[i-4].
    always_comb begin
        prev_idx = idx_q - 6'd1;
        back_idx = idx_q - 6'd4;
        temp     = w_q[prev_idx];
        if (idx_q[1:0] == 2'b00) begin
            temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon(idx_q[5:2]), 24'h0};
        end
        new_word = w_q[back_idx] ^ temp;
    end

    // FSM state and word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Word store: key words on load, one expanded word per cycle afterwards.
    // NOTE: the store has no reset; key_ready gates every read, so its contents never matter before a load.
    always_ff @(posedge clk) begin
        if (key_load) begin
            w_q[0] <= key_in[127:96];
            w_q[1] <= key_in[95:64];
            w_q[2] <= key_in[63:32];
            w_q[3] <= key_in[31:0];
        end else if (state_q == S_EXPAND) begin
            w_q[idx_q] <= new_word;
        end
    end

    assign rd_base = {rk_rd_round, 2'b00};

    // Registered read port; checks use pre-edge key_ready, so a read on a load edge sees the old key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_out_q   <= 128'h0;
            rk_valid_q <= 1'b0;
            rk_err_q   <= 1'b0;
        end else begin
            rk_valid_q <= rk_rd_en;
            rk_err_q   <= 1'b0;
            if (rk_rd_en) begin
                if (state_q == S_READY && rk_rd_round <= MAX_ROUND) begin
                    rk_out_q <= {w_q[rd_base], w_q[rd_base + 6'd1],
                                 w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
                end else begin
                    rk_err_q <= 1'b1;
                    if (ZERO_ON_INVALID) rk_out_q <= 128'h0;
                end
            end
        end
    end

    assign busy      = (state_q == S_EXPAND);
    assign key_ready = (state_q == S_READY);
    assign rk_out    = rk_out_q;
    assign rk_valid  = rk_valid_q;
    assign rk_err    = rk_err_q;

endmodule
